// File: rtl/openmips_pkg.sv
// -----------------------------------------------------------------------------
// openmips_pkg
// Shared definitions for the openMIPS register-file slice:
//   - default data / address widths
//   - ZeroWord constant
//   - register-file clear FSM state enum {CLEAR, READY}
//   - is_zero_addr(): hard-wired register-0 detection helper
// -----------------------------------------------------------------------------
package openmips_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } rf_state_e;

    // True when register 0 is hard-wired and the (zero-extended) address hits it.
    function automatic logic is_zero_addr(input logic zero_en, input logic [31:0] addr);
        return zero_en && (addr == 32'd0);
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
// Per-register pending bits for the multi-port register file.
//   clk, rst       : clock, synchronous active-high reset (clears all pending)
//   ready_i        : register file is in normal operation; all updates gated by it
//   we0_i/waddr0_i : write port 0 (clears pending[waddr0])
//   we1_i/waddr1_i : write port 1 (clears pending[waddr1])
//   resv_en_i/resv_addr_i : reservation (sets pending[resv_addr]); set beats clear
//   re_i, raddr_i  : per-port read enable / packed read addresses
//   hit_i          : per-port same-cycle bypass hit from the read muxes
//   rbusy_o        : read targets a pending register that is not bypassed
// -----------------------------------------------------------------------------
module regfile_scoreboard
    import openmips_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ready_i,
    input  logic                  we0_i,
    input  logic [ADDR_W-1:0]     waddr0_i,
    input  logic                  we1_i,
    input  logic [ADDR_W-1:0]     waddr1_i,
    input  logic                  resv_en_i,
    input  logic [ADDR_W-1:0]     resv_addr_i,
    input  logic [NRD-1:0]        re_i,
    input  logic [NRD*ADDR_W-1:0] raddr_i,
    input  logic [NRD-1:0]        hit_i,
    output logic [NRD-1:0]        rbusy_o
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [DEPTH-1:0] OneHot0 = {{(DEPTH-1){1'b0}}, 1'b1};
    localparam logic [DEPTH-1:0] NoBits  = {DEPTH{1'b0}};

    logic [DEPTH-1:0] pending_q;
    logic [DEPTH-1:0] pending_d;
    logic [DEPTH-1:0] clr_mask_s;
    logic [DEPTH-1:0] set_mask_s;
    logic             set_ok_s;

    // A reservation of the hard-wired zero register never marks it pending.
    assign set_ok_s   = ready_i & resv_en_i & ~is_zero_addr(ZERO_REG != 0, 32'(resv_addr_i));

    assign clr_mask_s = ((ready_i & we0_i) ? (OneHot0 << waddr0_i) : NoBits)
                      | ((ready_i & we1_i) ? (OneHot0 << waddr1_i) : NoBits);
    assign set_mask_s = set_ok_s ? (OneHot0 << resv_addr_i) : NoBits;

    // Next pending state: clears first, then sets, so a same-cycle reservation
    // (newer producer) survives a write-back to the same register.
    always_comb begin
        pending_d = (pending_q & ~clr_mask_s) | set_mask_s;
    end

    // Pending-bit register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= NoBits;
        end else begin
            pending_q <= pending_d;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_busy
        logic [ADDR_W-1:0] ra_s;
        assign ra_s       = raddr_i[i*ADDR_W +: ADDR_W];
        assign rbusy_o[i] = ready_i & re_i[i] & pending_q[ra_s] & ~hit_i[i]
                          & ~is_zero_addr(ZERO_REG != 0, 32'(ra_s));
    end

endmodule

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
// Multi-port GPR file: NRD combinational read ports, two write ports (port 1
// wins on address collision) with same-cycle write-to-read bypass, a hardware
// clear sweep after reset, and a pending scoreboard for decode hazard checks.
//   clk, rst            : clock, synchronous active-high reset
//   init_done           : high once the clear sweep has finished
//   we0/waddr0/wdata0   : write port 0
//   we1/waddr1/wdata1   : write port 1 (higher priority)
//   re, raddr, rdata    : per-port read enable, packed addresses, packed data
//   rbusy               : per-port "reads a pending, non-bypassed register"
//   resv_en, resv_addr  : mark a register pending
// -----------------------------------------------------------------------------
module regfile_mp
    import openmips_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  init_done,
    input  logic                  we0,
    input  logic [ADDR_W-1:0]     waddr0,
    input  logic [DATA_W-1:0]     wdata0,
    input  logic                  we1,
    input  logic [ADDR_W-1:0]     waddr1,
    input  logic [DATA_W-1:0]     wdata1,
    input  logic [NRD-1:0]        re,
    input  logic [NRD*ADDR_W-1:0] raddr,
    output logic [NRD*DATA_W-1:0] rdata,
    output logic [NRD-1:0]        rbusy,
    input  logic                  resv_en,
    input  logic [ADDR_W-1:0]     resv_addr
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] IdxZero = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] IdxOne  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] IdxLast = {ADDR_W{1'b1}};
    localparam logic [DATA_W-1:0] DataZero = DATA_W'(ZeroWord);

    rf_state_e         state_q;
    rf_state_e         state_d;
    logic [ADDR_W-1:0] clr_idx_q;
    logic [ADDR_W-1:0] clr_idx_d;
    logic [DATA_W-1:0] regs_q [DEPTH];

    logic              ready_s;
    logic              wr0_s;
    logic              wr1_s;
    logic [NRD-1:0]    hit_s;

    assign ready_s   = (state_q == READY);
    assign init_done = ready_s;

    // Writes to the hard-wired zero register are dropped; nothing commits during the sweep.
    assign wr0_s = ready_s & we0 & ~is_zero_addr(ZERO_REG != 0, 32'(waddr0));
    assign wr1_s = ready_s & we1 & ~is_zero_addr(ZERO_REG != 0, 32'(waddr1));

    // Clear-sweep FSM next state: walk every index once, then settle in READY.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            CLEAR: begin
                clr_idx_d = clr_idx_q + IdxOne;
                if (clr_idx_q == IdxLast) begin
                    state_d = READY;
                end else begin
                    state_d = CLEAR;
                end
            end
            READY: begin
                state_d   = READY;
                clr_idx_d = IdxZero;
            end
            default: begin
                state_d   = CLEAR;
                clr_idx_d = IdxZero;
            end
        endcase
    end

    // Clear-sweep FSM state and index registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_idx_q <= IdxZero;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // Storage array: zeroed one entry per cycle by the sweep, then written by
    // the two ports; port 1 is assigned last so it wins on a shared address.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (!ready_s) begin
                regs_q[clr_idx_q] <= DataZero;
            end else begin
                if (wr0_s) begin
                    regs_q[waddr0] <= wdata0;
                end
                if (wr1_s) begin
                    regs_q[waddr1] <= wdata1;
                end
            end
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra_s;
        logic [DATA_W-1:0] rd_s;
        logic              zr_s;

        assign ra_s = raddr[i*ADDR_W +: ADDR_W];
        assign zr_s = is_zero_addr(ZERO_REG != 0, 32'(ra_s));

        // A bypass hit is only meaningful when the read would actually use write data.
        assign hit_s[i] = ready_s & re[i] & ~zr_s
                        & ((we1 & (waddr1 == ra_s)) | (we0 & (waddr0 == ra_s)));

        // Read mux: disabled/not-ready, zero register, port-1 bypass, port-0 bypass, array.
        always_comb begin
            rd_s = DataZero;
            if (!ready_s || !re[i]) begin
                rd_s = DataZero;
            end else if (zr_s) begin
                rd_s = DataZero;
            end else if (we1 && (waddr1 == ra_s)) begin
                rd_s = wdata1;
            end else if (we0 && (waddr0 == ra_s)) begin
                rd_s = wdata0;
            end else begin
                rd_s = regs_q[ra_s];
            end
        end

        assign rdata[i*DATA_W +: DATA_W] = rd_s;
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NRD      (NRD),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .ready_i     (ready_s),
        .we0_i       (we0),
        .waddr0_i    (waddr0),
        .we1_i       (we1),
        .waddr1_i    (waddr1),
        .resv_en_i   (resv_en),
        .resv_addr_i (resv_addr),
        .re_i        (re),
        .raddr_i     (raddr),
        .hit_i       (hit_s),
        .rbusy_o     (rbusy)
    );

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port general-purpose register file for the openMIPS pipeline, replacing the fixed 2-read/1-write file. It provides NRD combinational read ports and two write ports with same-cycle write-to-read bypass, and hardware-clears every register after reset. A per-register pending scoreboard lets decode detect reads of registers whose producer has not yet written back. It sits between ID (reads, reservations) and WB (writes).

## Interface
Parameters:
- DATA_W, 32, register width
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W
- NRD, 2, number of read ports
- ZERO_REG, 1, if 1 then register 0 always reads 0, ignores writes and ignores reservations

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- init_done  out  1  high once the clear sweep has finished
- we0  in  1  write enable, port 0
- waddr0  in  ADDR_W  write address, port 0
- wdata0  in  DATA_W  write data, port 0
- we1  in  1  write enable, port 1 (higher priority)
- waddr1  in  ADDR_W  write address, port 1
- wdata1  in  DATA_W  write data, port 1
- re  in  NRD  per-port read enable
- raddr  in  NRD*ADDR_W  packed read addresses; port i at [i*ADDR_W +: ADDR_W]
- rdata  out  NRD*DATA_W  packed read data (combinational)
- rbusy  out  NRD  read i targets a pending register that is not bypassed this cycle
- resv_en  in  1  mark resv_addr pending
- resv_addr  in  ADDR_W  register to reserve

## Operation
- FSM states:
  - CLEAR: entered on rst. Counter clr_idx runs 0..DEPTH-1 and writes 0 to regs[clr_idx] each cycle. On clr_idx == DEPTH-1, go to READY.
  - READY: normal operation; stays in READY until rst.
- In CLEAR: we0, we1 and resv_en are ignored; every rdata is 0, every rbusy is 0, init_done is 0.
- Write (READY): port p commits wdata_p to regs[waddr_p] on the clk edge when we_p = 1, unless ZERO_REG and waddr_p == 0. If both ports write the same address, port 1's data is stored.
- Read port i, priority order:
  1. state != READY or re[i] = 0 -> 0
  2. ZERO_REG and raddr_i == 0 -> 0
  3. we1 and waddr1 == raddr_i -> wdata1
  4. we0 and waddr0 == raddr_i -> wdata0
  5. otherwise regs[raddr_i]
- Scoreboard: pending[DEPTH] bits.
  - A write on either port clears pending[waddr].
  - resv_en sets pending[resv_addr].
  - If a reservation and a write target the same address in the same cycle, the set wins (the reservation belongs to a newer producer).
  - Reservations of register 0 are ignored when ZERO_REG = 1.
- rbusy[i] = READY & re[i] & pending[raddr_i] & no bypass hit for port i & !(ZERO_REG & raddr_i == 0).

## Timing
- Reset values: init_done 0, pending all 0, rdata 0, rbusy 0. State CLEAR, clr_idx 0.
- CLEAR lasts exactly DEPTH cycles after the rst-deassert edge; init_done rises on the following edge. With ADDR_W = 5, init_done is high in cycle 32 after rst falls.
- rst asserted mid-sweep restarts the sweep at index 0. rst asserted in READY zeroes pending and re-enters CLEAR.
- Write latency: data is visible via bypass in the same cycle and from the array starting the next cycle.
- pending changes are visible on rbusy starting the cycle after resv_en / the write.

## Structure
- Shared package (openmips_pkg): default DATA_W/ADDR_W, ZeroWord, and the FSM state enum {CLEAR, READY}.
- One sub-module, regfile_scoreboard: the pending bits, set/clear priority, and per-port busy lookup.
- The storage array, clear FSM and read muxes live in the top module, with the read mux generated per port.

## Test plan
- Clear sweep: preload regs through a back-door force, apply rst for 1 cycle, then read reg 7 at cycle 31 -> rdata 0, init_done 0. At cycle 32 -> init_done 1, reg 7 still reads 0.
- Bypass priority: in the same cycle write reg 3 with 0xAAAA0000 on port 0 and 0x5555FFFF on port 1 while reading reg 3 -> rdata 0x5555FFFF that cycle and on the next cycle's array read.
- Zero register: with ZERO_REG = 1, write 0xDEADBEEF to reg 0 and reserve reg 0 -> rdata 0 and rbusy 0 on all ports.
- Scoreboard: reserve reg 9 -> next cycle rbusy 1. A write of 0x12 to reg 9 in the same cycle as the read -> rbusy 0, rdata 0x12. After the write, pending is clear.
- Reserve and write the same register in the same cycle: resv reg 4 and write reg 4 -> pending[4] stays 1, so the next-cycle read of reg 4 gives rbusy 1.
- Reset mid-sweep: assert rst at cycle 10 of CLEAR; init_done then rises exactly 32 cycles after the second rst deassertion.
